// File: rtl/io_port_unit.sv
// I/O port responder for the EM stage: buffers device input words in a circular
// FIFO for IN and holds the OUT word in a valid/ack register, stalling when needed.
module io_port_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             stall,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [CNT_W-1:0] in_count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } out_state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    out_state_e       state_q, state_d;

    logic rd_req_s;
    logic wr_req_s;
    logic push_s;
    logic pop_s;
    logic empty_s;
    logic in_ready_s;

    // A simultaneous IN/OUT request is treated as a read only
    assign rd_req_s   = io_en & io_rd;
    assign wr_req_s   = io_en & io_wr & ~io_rd;
    assign empty_s    = (count_q == {CNT_W{1'b0}});
    assign in_ready_s = (count_q < CNT_W'(DEPTH)) & reset;
    assign push_s     = in_valid & in_ready_s;
    assign pop_s      = rd_req_s & ~empty_s;

    // FIFO pointer, occupancy and IN-result next-state
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (push_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d     = head_q + PTR_W'(1);
            rd_data_d  = mem_q[head_q];
            rd_valid_d = 1'b1;
        end else begin
            head_d     = head_q;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // OUT handshake next-state; a held word plus a new write without ack stalls
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (wr_req_s) begin
                    state_d    = HOLD;
                    out_data_d = wr_data;
                end else begin
                    state_d    = IDLE;
                    out_data_d = out_data_q;
                end
            end
            HOLD: begin
                if (out_ack && wr_req_s) begin
                    state_d    = HOLD;
                    out_data_d = wr_data;
                end else if (out_ack) begin
                    state_d    = IDLE;
                    out_data_d = out_data_q;
                end else begin
                    state_d    = HOLD;
                    out_data_d = out_data_q;
                end
            end
            default: begin
                state_d    = IDLE;
                out_data_d = out_data_q;
            end
        endcase
    end

    // Control and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            rd_data_q  <= {WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
            out_data_q <= {WIDTH{1'b0}};
            state_q    <= IDLE;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            out_data_q <= out_data_d;
            state_q    <= state_d;
        end
    end

    // Storage array needs no reset: occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[tail_q] <= in_data;
        end
    end

    assign stall     = (rd_req_s & empty_s) | (wr_req_s & (state_q == HOLD) & ~out_ack);
    assign in_ready  = in_ready_s;
    assign in_count  = count_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign out_data  = out_data_q;
    assign out_valid = (state_q == HOLD);

endmodule

// File: doc/io_port_unit.md
# io_port_unit

I/O port responder for the five-stage pipeline. It serves the IN and OUT instructions that the memory stage issues through the IOE/IOR/IOW control bits. Incoming device words are buffered in a small input FIFO, and the outgoing word is held in an output register with a valid/ack handshake. When a request cannot be served, the unit raises a stall to the pipeline.

## Interface
Parameters:
- WIDTH, 16: data word width (processor register width)
- DEPTH, 4: input FIFO entries; must be a power of two, at least 2
- CNT_W, 3: width of the occupancy count; equals log2(DEPTH)+1

Ports:
- clk, input, 1: single clock; all state updates on the rising edge
- reset, input, 1: asynchronous, active-low reset
- io_en, input, 1: IOE bit from the EM pipeline control word
- io_rd, input, 1: IOR bit; IN request
- io_wr, input, 1: IOW bit; OUT request
- wr_data, input, WIDTH: Rdst value to send on OUT
- rd_data, output, WIDTH: word returned for IN, feeding the write-back mux
- rd_valid, output, 1: one-cycle pulse marking rd_data as new
- stall, output, 1: combinational; the pipeline must hold the EM stage while this is high
- in_data, input, WIDTH: device input word
- in_valid, input, 1: device offers in_data
- in_ready, output, 1: FIFO can accept a word
- out_data, output, WIDTH: held output word
- out_valid, output, 1: out_data is pending for the device
- out_ack, input, 1: device consumes out_data
- in_count, output, CNT_W: current FIFO occupancy

## Operation
- Definitions:
  - rd_req = io_en & io_rd
  - wr_req = io_en & io_wr & ~io_rd
  - io_rd and io_wr asserted together: the read wins and the write is ignored entirely.
- Input FIFO:
  - Circular buffer with head and tail pointers of log2(DEPTH) bits; pointers wrap modulo DEPTH.
  - in_ready = (in_count < DEPTH) & reset.
  - Push on in_valid & in_ready: write at the tail, tail+1.
- IN:
  - If rd_req and count>0: pop the head; rd_data <= mem[head]; rd_valid <= 1; head+1.
  - If rd_req and count==0: stall=1, no pop, rd_valid <= 0.
  - No bypass: a word pushed in the same cycle as the read does not satisfy it.
  - Push and pop in the same cycle: in_count unchanged.
  - When the FIFO is full, in_ready=0, so a pop frees a slot that can be pushed on the next cycle.
- OUT handshake state machine:
  - States are IDLE (out_valid=0) and HOLD (out_valid=1).
  - IDLE, wr_req: out_data <= wr_data, go to HOLD, no stall.
  - HOLD, out_ack, no wr_req: go to IDLE; out_data keeps its value.
  - HOLD, out_ack & wr_req: out_data <= wr_data, stay in HOLD, no stall (back-to-back send).
  - HOLD, wr_req, no out_ack: stall=1, out_data unchanged.
  - IDLE, out_ack: ignored.
- stall = (rd_req & count==0) | (wr_req & HOLD & ~out_ack).
- With io_en low, io_rd and io_wr are ignored: no action and no stall.
- rd_valid is 0 in every cycle without a successful pop; rd_data holds its last value.

## Timing
- Reset (reset low, asynchronous) forces:
  - head=tail=0, in_count=0
  - rd_data=0, rd_valid=0
  - out_data=0, out_valid=0, state IDLE
  - in_ready=0
- Reset asserted mid-operation discards FIFO contents and any pending output word immediately, without waiting for a clock edge.
- Push latency: a word accepted at edge N can be popped by a request at edge N+1. in_count reflects the push after edge N.
- IN latency: a request accepted at edge N gives rd_data and rd_valid=1 after edge N, for exactly one cycle.
- OUT latency: a request accepted at edge N gives out_valid=1 after edge N. An ack at edge M gives out_valid=0 after M (unless a back-to-back write occurs).
- stall is combinational from the current inputs and state. A stalled request retries each cycle while the inputs are held and succeeds on the first cycle its condition clears.

## Test plan
- Reset then fill: reset low then high; push 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles. Required: in_count=4, in_ready=0; a fifth word 0x5555 is not accepted.
- Drain: from full, issue IN for four cycles. Required: rd_data 0x1111, 0x2222, 0x3333, 0x4444 with rd_valid=1 each cycle; in_count=0; a fifth IN gives stall=1 and rd_valid=0.
- IN on empty with a simultaneous push of 0xABCD: stall=1 that cycle; the retry next cycle returns 0xABCD with stall=0.
- Wrap-around: perform 6 push/pop pairs at in_count=1 with a concurrent push and pop each cycle. Required: in_count stays 1, data order is preserved, pointers wrap past DEPTH-1.
- OUT handshake:
  - OUT 0x00FF; required out_valid=1, out_data=0x00FF.
  - OUT 0x0F0F with no ack; required stall=1.
  - Assert out_ack in the same cycle; required out_data=0x0F0F, out_valid stays 1, stall=0.
  - Ack alone; required out_valid=0.
- Reset mid-operation: with FIFO count=2 and out_valid=1, pull reset low between edges. Required: in_count=0, out_valid=0, rd_valid=0 immediately. io_rd and io_wr asserted together then cause only the read.
